dp_ram_gen: RTL and testbench

Parametrised single-clock true dual-port RAM, successor to the fixed 16x8 dual-port RAM. Generalises data width and depth, adds a configurable read-during-write mode, a deterministic same-address write-collision policy, per-port read-valid strobes, and a hardware clear sequencer that zeroes the array after reset or on request. It sits as the shared scratch store between two independent requesters on one clock domain.

---
 rtl/dp_ram_gen_pkg.sv | 8 +
 rtl/dp_ram_clear_seq.sv | 68 ++++++
 rtl/dp_ram_gen.sv | 142 ++++++++++++++
 tb/tb_dp_ram_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_gen_pkg.sv
// Shared types for the parametrised dual-port RAM and its clear sequencer.
package dp_ram_gen_pkg;

  typedef enum logic {READ_FIRST  = 1'b0, WRITE_FIRST = 1'b1} rdw_mode_e;
  typedef enum logic {PORT_A      = 1'b0, PORT_B      = 1'b1} wr_prio_e;
  typedef enum logic {CLEAR       = 1'b0, READY       = 1'b1} state_e;

endpackage

// File: rtl/dp_ram_clear_seq.sv
// Clear sequencer: sweeps every address writing zero after reset or on a clr
// pulse, then hands the array over to the ports.
module dp_ram_clear_seq
  import dp_ram_gen_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              init_busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and sweep counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: a clr pulse always restarts the sweep from address 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_ADDR) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign init_busy = (state_q == CLEAR);
  assign clr_we    = (state_q == CLEAR);
  assign clr_addr  = cnt_q;
  assign ready     = (state_q == READY);

endmodule

// File: rtl/dp_ram_gen.sv
// Single-clock true dual-port RAM with selectable read-during-write behaviour,
// deterministic same-address write priority and a hardware clear sweep.
module dp_ram_gen
  import dp_ram_gen_pkg::*;
#(
  parameter int        DATA_W   = 8,
  parameter int        ADDR_W   = 4,
  parameter rdw_mode_e RDW_MODE = READ_FIRST,
  parameter wr_prio_e  WR_PRIO  = PORT_A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              init_busy,
  input  logic [DATA_W-1:0] din_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic              we_a,
  input  logic              re_a,
  output logic [DATA_W-1:0] dout_a,
  output logic              dvalid_a,
  input  logic [DATA_W-1:0] din_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              we_b,
  input  logic              re_b,
  output logic [DATA_W-1:0] dout_b,
  output logic              dvalid_b,
  output logic              collision
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              ready;
  logic              acc;
  logic              coll;
  logic              wa;
  logic              wb;

  logic [DATA_W-1:0] dout_a_q, dout_a_d;
  logic [DATA_W-1:0] dout_b_q, dout_b_d;
  logic              dvalid_a_q, dvalid_a_d;
  logic              dvalid_b_q, dvalid_b_d;
  logic              collision_q, collision_d;

  dp_ram_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .ready     (ready)
  );

  // Word seen by a reader at raddr this edge; under WRITE_FIRST the
  // already-resolved write enables guarantee only the winner is forwarded.
  function automatic logic [DATA_W-1:0] rd_word(
    input logic [DATA_W-1:0] old_word,
    input logic [ADDR_W-1:0] raddr
  );
    logic [DATA_W-1:0] w;
    w = old_word;
    if (RDW_MODE == WRITE_FIRST) begin
      if (wb && (addr_b == raddr)) begin
        w = din_b;
      end else if (wa && (addr_a == raddr)) begin
        w = din_a;
      end else begin
        w = old_word;
      end
    end
    return w;
  endfunction

  // Port access qualification and collision resolution
  always_comb begin
    acc  = ready && !clr;
    coll = acc && we_a && we_b && (addr_a == addr_b);
    wa   = acc && we_a && !(coll && (WR_PRIO == PORT_B));
    wb   = acc && we_b && !(coll && (WR_PRIO == PORT_A));
  end

  // Read-path next values; dout holds when no read is accepted
  always_comb begin
    dout_a_d    = dout_a_q;
    dout_b_d    = dout_b_q;
    dvalid_a_d  = acc && re_a;
    dvalid_b_d  = acc && re_b;
    collision_d = coll;
    if (acc && re_a) begin
      dout_a_d = rd_word(mem_q[addr_a], addr_a);
    end else begin
      dout_a_d = dout_a_q;
    end
    if (acc && re_b) begin
      dout_b_d = rd_word(mem_q[addr_b], addr_b);
    end else begin
      dout_b_d = dout_b_q;
    end
  end

  // Registered port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_a_q    <= '0;
      dout_b_q    <= '0;
      dvalid_a_q  <= 1'b0;
      dvalid_b_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      dout_a_q    <= dout_a_d;
      dout_b_q    <= dout_b_d;
      dvalid_a_q  <= dvalid_a_d;
      dvalid_b_q  <= dvalid_b_d;
      collision_q <= collision_d;
    end
  end

  // Storage array: left untouched by reset so it maps onto RAM macros
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else begin
      if (wa) begin
        mem_q[addr_a] <= din_a;
      end
      if (wb) begin
        mem_q[addr_b] <= din_b;
      end
    end
  end

  assign dout_a    = dout_a_q;
  assign dout_b    = dout_b_q;
  assign dvalid_a  = dvalid_a_q;
  assign dvalid_b  = dvalid_b_q;
  assign collision = collision_q;

endmodule

// File: tb/tb_dp_ram_gen.sv
// Directed bench: a default RAM (READ_FIRST, PORT_A) and a WRITE_FIRST/PORT_B
// variant driven by the same stimulus, checked against hand-computed values.
module tb_dp_ram_gen;
  import dp_ram_gen_pkg::*;

  logic       clk = 1'b0;
  logic       rst, clr;
  logic [7:0] din_a, din_b;
  logic [3:0] addr_a, addr_b;
  logic       we_a, we_b, re_a, re_b;

  logic       busy0, dva0, dvb0, col0;
  logic [7:0] douta0, doutb0;
  logic       busy1, dva1, dvb1, col1;
  logic [7:0] douta1, doutb1;

  int passed = 0;
  int total  = 0;
  int n;

  always #5 clk = ~clk;

  dp_ram_gen dut0 (
    .clk(clk), .rst(rst), .clr(clr), .init_busy(busy0),
    .din_a(din_a), .addr_a(addr_a), .we_a(we_a), .re_a(re_a),
    .dout_a(douta0), .dvalid_a(dva0),
    .din_b(din_b), .addr_b(addr_b), .we_b(we_b), .re_b(re_b),
    .dout_b(doutb0), .dvalid_b(dvb0), .collision(col0)
  );

  dp_ram_gen #(.RDW_MODE(WRITE_FIRST), .WR_PRIO(PORT_B)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .init_busy(busy1),
    .din_a(din_a), .addr_a(addr_a), .we_a(we_a), .re_a(re_a),
    .dout_a(douta1), .dvalid_a(dva1),
    .din_b(din_b), .addr_b(addr_b), .we_b(we_b), .re_b(re_b),
    .dout_b(doutb1), .dvalid_b(dvb1), .collision(col1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 1'b0; we_a = 1'b0; we_b = 1'b0; re_a = 1'b0; re_b = 1'b0;
  endtask

  // Counts edges until both instances drop init_busy, bounded at 40
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while ((busy0 || busy1) && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; idle();
    din_a = 8'h00; din_b = 8'h00; addr_a = 4'h0; addr_b = 4'h0;
    tick(); tick();
    chk("rst_busy0", {31'd0, busy0}, 32'd1);
    chk("rst_busy1", {31'd0, busy1}, 32'd1);
    chk("rst_douta0", {24'd0, douta0}, 32'd0);
    chk("rst_doutb1", {24'd0, doutb1}, 32'd0);
    chk("rst_dvalid", {30'd0, dva0, dvb1}, 32'd0);
    chk("rst_collision", {30'd0, col0, col1}, 32'd0);

    rst = 1'b0;
    wait_ready(n);
    chk("sweep_len_after_reset", n, 32'd16);

    // Every word zero after the power-up sweep
    for (int i = 0; i < 16; i++) begin
      re_b = 1'b1; addr_b = 4'(i);
      tick();
      chk($sformatf("zero_rd%0d", i), {24'd0, doutb0}, 32'd0);
    end
    idle(); tick();

    for (int i = 0; i < 16; i++) begin
      we_a = 1'b1; addr_a = 4'(i); din_a = 8'(i);
      tick();
    end
    idle();

    // Back-to-back reads: one word per cycle, dvalid continuous
    for (int i = 0; i < 16; i++) begin
      re_b = 1'b1; addr_b = 4'(i);
      tick();
      chk($sformatf("b2b_dout%0d", i), {24'd0, doutb0}, 32'(i));
      chk($sformatf("b2b_dvalid%0d", i), {31'd0, dvb0}, 32'd1);
    end
    re_b = 1'b0;
    tick();
    chk("dvalid_drops", {31'd0, dvb0}, 32'd0);
    chk("dout_holds", {24'd0, doutb0}, 32'h0F);

    // Same-address dual write with a concurrent read on port A
    we_a = 1'b1; addr_a = 4'd3; din_a = 8'hAA; re_a = 1'b1;
    we_b = 1'b1; addr_b = 4'd3; din_b = 8'h55;
    tick();
    chk("coll_strobe0", {31'd0, col0}, 32'd1);
    chk("coll_strobe1", {31'd0, col1}, 32'd1);
    chk("coll_rd_readfirst", {24'd0, douta0}, 32'h03);
    chk("coll_rd_writefirst_winner", {24'd0, douta1}, 32'h55);
    idle();
    tick();
    chk("coll_one_cycle", {30'd0, col0, col1}, 32'd0);
    re_a = 1'b1; addr_a = 4'd3;
    tick();
    chk("coll_prio_a", {24'd0, douta0}, 32'hAA);
    chk("coll_prio_b", {24'd0, douta1}, 32'h55);

    // Dual write to different addresses: both stored, no collision
    idle();
    we_a = 1'b1; addr_a = 4'd5; din_a = 8'h12;
    we_b = 1'b1; addr_b = 4'd6; din_b = 8'h34;
    tick();
    chk("nocoll_strobe", {30'd0, col0, col1}, 32'd0);
    idle();
    re_a = 1'b1; addr_a = 4'd5; re_b = 1'b1; addr_b = 4'd6;
    tick();
    chk("nocoll_a", {24'd0, douta0}, 32'h12);
    chk("nocoll_b", {24'd0, doutb1}, 32'h34);

    // Cross-port read during write
    idle();
    we_a = 1'b1; addr_a = 4'd1; din_a = 8'h11;
    tick();
    din_a = 8'hBB; re_b = 1'b1; addr_b = 4'd1;
    tick();
    chk("rdw_read_first", {24'd0, doutb0}, 32'h11);
    chk("rdw_write_first", {24'd0, doutb1}, 32'hBB);
    idle();
    re_a = 1'b1; addr_a = 4'd1; re_b = 1'b1; addr_b = 4'd1;
    tick();
    chk("dual_rd_a", {24'd0, douta0}, 32'hBB);
    chk("dual_rd_b", {24'd0, doutb0}, 32'hBB);
    chk("dual_rd_nocoll", {31'd0, col0}, 32'd0);

    // clr pulse with an access on the same edge; reads ignored during sweep
    idle();
    clr = 1'b1; we_a = 1'b1; addr_a = 4'd2; din_a = 8'h77; re_a = 1'b1;
    tick();
    chk("clr_busy", {31'd0, busy0}, 32'd1);
    chk("clr_edge_no_dvalid", {31'd0, dva0}, 32'd0);
    clr = 1'b0; we_a = 1'b0;
    n = 0;
    while ((busy0 || busy1) && n < 40) begin
      tick();
      n++;
      if (dva0 || dva1) chk($sformatf("sweep_dvalid%0d", n), {30'd0, dva0, dva1}, 32'd0);
    end
    chk("sweep_len_after_clr", n, 32'd16);
    for (int i = 0; i < 16; i++) begin
      re_a = 1'b1; addr_a = 4'(i);
      tick();
      chk($sformatf("clr_zero%0d", i), {24'd0, douta0}, 32'd0);
    end

    // Reset part-way through a sweep
    idle();
    we_a = 1'b1; addr_a = 4'd10; din_a = 8'h5A;
    tick();
    we_a = 1'b0; re_a = 1'b1;
    tick();
    re_a = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    chk("sweep_holds_dout", {24'd0, douta0}, 32'h5A);
    rst = 1'b1;
    #1;
    chk("async_rst_dout", {24'd0, douta0}, 32'd0);
    chk("async_rst_busy", {31'd0, busy1}, 32'd1);
    tick();
    rst = 1'b0;
    wait_ready(n);
    chk("sweep_len_after_midrst", n, 32'd16);
    re_a = 1'b1; addr_a = 4'd10;
    tick();
    chk("midrst_word_cleared", {24'd0, douta0}, 32'd0);
    chk("midrst_dvalid", {31'd0, dva0}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
